// File: rtl/sdram_ctrl.sv
// SDRAM command sequencer: closed-page single-word read/write plus periodic auto refresh.
// Latency: accept at cycle 0 -> ACTIVE +1, READ/WRITE +tRCD+1, rsp_valid +tRCD+CL+2 (reads).
// Backpressure: req_ready only in IDLE with no refresh pending; host holds the request otherwise.
// Ports: clk/reset (sync, active high), init_done level, host req_*/rsp_*, registered sdram_* pins.
module sdram_ctrl #(
    parameter int BA_WIDTH   = 2,
    parameter int ROW_WIDTH  = 13,
    parameter int COL_WIDTH  = 9,
    parameter int DATA_WIDTH = 16,
    parameter int CL         = 2,
    parameter int tRCD_CYCLE = 2,
    parameter int tRP_CYCLE  = 2,
    parameter int tWR_CYCLE  = 2,
    parameter int tRFC_CYCLE = 7,
    parameter int tREF_CYCLE = 781
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    init_done,
    input  logic                                    req_valid,
    output logic                                    req_ready,
    input  logic                                    req_write,
    input  logic [BA_WIDTH+ROW_WIDTH+COL_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0]                   req_wdata,
    input  logic [DATA_WIDTH/8-1:0]                 req_wmask,
    output logic                                    rsp_valid,
    output logic [DATA_WIDTH-1:0]                   rsp_rdata,
    output logic                                    sdram_cs_n,
    output logic                                    sdram_ras_n,
    output logic                                    sdram_cas_n,
    output logic                                    sdram_we_n,
    output logic                                    sdram_cke,
    output logic [BA_WIDTH-1:0]                     sdram_ba,
    output logic [ROW_WIDTH-1:0]                    sdram_addr,
    output logic [DATA_WIDTH/8-1:0]                 sdram_dqm,
    output logic [DATA_WIDTH-1:0]                   sdram_dq_out,
    output logic                                    sdram_dq_oe,
    input  logic [DATA_WIDTH-1:0]                   sdram_dq_in
);
    localparam int ADDR_W = BA_WIDTH + ROW_WIDTH + COL_WIDTH;
    localparam int DM_W   = DATA_WIDTH / 8;
    localparam int MAX_A  = (tREF_CYCLE > tRFC_CYCLE) ? tREF_CYCLE : tRFC_CYCLE;
    localparam int MAX_B  = ((tWR_CYCLE + tRP_CYCLE) > CL) ? (tWR_CYCLE + tRP_CYCLE) : CL;
    localparam int MAX_C  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_P  = (MAX_C > tRCD_CYCLE) ? MAX_C : tRCD_CYCLE;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_INHIBIT = 4'b1111;
    localparam logic [3:0] CMD_NOP     = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE  = 4'b0011;
    localparam logic [3:0] CMD_READ    = 4'b0101;
    localparam logic [3:0] CMD_WRITE   = 4'b0100;
    localparam logic [3:0] CMD_REFRESH = 4'b0001;

    typedef enum logic [2:0] {
        S_WAIT_INIT, S_IDLE, S_ACT, S_RW, S_RD_WAIT, S_WR_REC, S_REF
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      tmr_q, tmr_d;
    logic                  ref_pend_q, ref_pend_d;
    logic [3:0]            cmd_q, cmd_d;
    logic                  cke_q, cke_d;
    logic [BA_WIDTH-1:0]   ba_q, ba_d;
    logic [ROW_WIDTH-1:0]  addr_q, addr_d;
    logic [DM_W-1:0]       dqm_q, dqm_d;
    logic [DATA_WIDTH-1:0] dq_out_q, dq_out_d;
    logic                  dq_oe_q, dq_oe_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  wr_q, wr_d;
    logic [ADDR_W-1:0]     raddr_q, raddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DM_W-1:0]       wmask_q, wmask_d;
    logic                  ref_set;
    logic [ROW_WIDTH-1:0]  col_addr;

    // Column address with A10 high selects auto-precharge.
    always_comb begin
        col_addr                  = '0;
        col_addr[COL_WIDTH-1:0]   = raddr_q[COL_WIDTH-1:0];
        col_addr[10]              = 1'b1;
    end

    assign req_ready = (state_q == S_IDLE) && !ref_pend_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ref_pend_d  = ref_pend_q;
        cmd_d       = CMD_NOP;
        cke_d       = 1'b1;
        ba_d        = ba_q;
        addr_d      = addr_q;
        dqm_d       = '1;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        wr_d        = wr_q;
        raddr_d     = raddr_q;
        wdata_d     = wdata_q;
        wmask_d     = wmask_q;
        ref_set     = 1'b0;

        // Refresh interval timer; only the reload ends a count.
        if (!init_done) begin
            tmr_d = CNT_W'(tREF_CYCLE - 1);
        end else if (tmr_q == '0) begin
            tmr_d   = CNT_W'(tREF_CYCLE - 1);
            ref_set = 1'b1;
        end else begin
            tmr_d = tmr_q - 1'b1;
        end

        case (state_q)
            S_WAIT_INIT: begin
                cmd_d = CMD_INHIBIT;
                cke_d = 1'b0;
                if (init_done) begin
                    state_d = S_IDLE;
                    cmd_d   = CMD_NOP;
                    cke_d   = 1'b1;
                end
            end
            S_IDLE: begin
                if (ref_pend_q) begin
                    cmd_d      = CMD_REFRESH;
                    ref_pend_d = 1'b0;
                    cnt_d      = CNT_W'(tRFC_CYCLE - 1);
                    state_d    = S_REF;
                end else if (req_valid) begin
                    wr_d    = req_write;
                    raddr_d = req_addr;
                    wdata_d = req_wdata;
                    wmask_d = req_wmask;
                    cmd_d   = CMD_ACTIVE;
                    ba_d    = req_addr[ADDR_W-1 -: BA_WIDTH];
                    addr_d  = req_addr[COL_WIDTH +: ROW_WIDTH];
                    cnt_d   = CNT_W'(tRCD_CYCLE - 1);
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                // The column command is registered here so it lands on the
                // pins in the first RW cycle.
                if (cnt_q == '0) begin
                    ba_d    = raddr_q[ADDR_W-1 -: BA_WIDTH];
                    addr_d  = col_addr;
                    state_d = S_RW;
                    if (wr_q) begin
                        cmd_d    = CMD_WRITE;
                        dq_oe_d  = 1'b1;
                        dq_out_d = wdata_q;
                        dqm_d    = ~wmask_q;
                    end else begin
                        cmd_d = CMD_READ;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RW: begin
                if (wr_q) begin
                    cnt_d   = CNT_W'(tWR_CYCLE + tRP_CYCLE - 1);
                    state_d = S_WR_REC;
                end else begin
                    cnt_d   = CNT_W'(CL);
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                // cnt==1 is exactly CL cycles after READ was on the pins.
                if (cnt_q == CNT_W'(1)) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = sdram_dq_in;
                end
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_WR_REC, S_REF: begin
                if (cnt_q == '0) state_d = S_IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = S_WAIT_INIT;
        endcase

        // A new timer expiry beats the clear; an expiry while already pending merges.
        if (ref_set) ref_pend_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_WAIT_INIT;
            cnt_q       <= '0;
            tmr_q       <= CNT_W'(tREF_CYCLE - 1);
            ref_pend_q  <= 1'b0;
            cmd_q       <= CMD_INHIBIT;
            cke_q       <= 1'b0;
            ba_q        <= '0;
            addr_q      <= '0;
            dqm_q       <= '1;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_q        <= 1'b0;
            raddr_q     <= '0;
            wdata_q     <= '0;
            wmask_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmr_q       <= tmr_d;
            ref_pend_q  <= ref_pend_d;
            cmd_q       <= cmd_d;
            cke_q       <= cke_d;
            ba_q        <= ba_d;
            addr_q      <= addr_d;
            dqm_q       <= dqm_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_q        <= wr_d;
            raddr_q     <= raddr_d;
            wdata_q     <= wdata_d;
            wmask_q     <= wmask_d;
        end
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_q;
    assign sdram_cke    = cke_q;
    assign sdram_ba     = ba_q;
    assign sdram_addr   = addr_q;
    assign sdram_dqm    = dqm_q;
    assign sdram_dq_out = dq_out_q;
    assign sdram_dq_oe  = dq_oe_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
endmodule

// File: tb/tb_sdram_ctrl.sv
// Directed bench for sdram_ctrl with a small SDRAM behavioural model.
// Latency: commands and responses are logged with cycle stamps and checked against hand timings.
// Backpressure: host holds req_valid until req_ready is seen.
module tb_sdram_ctrl;
    localparam int CL = 2;
    localparam logic [3:0] C_INH = 4'b1111, C_NOP = 4'b0111, C_ACT = 4'b0011;
    localparam logic [3:0] C_RD = 4'b0101, C_WR = 4'b0100, C_REF = 4'b0001;

    logic        clk = 1'b0;
    logic        reset, init_done, req_valid, req_ready, req_write;
    logic [23:0] req_addr;
    logic [15:0] req_wdata, rsp_rdata, dq_out, dq_in;
    logic [1:0]  req_wmask, ba, dqm;
    logic        rsp_valid, cs_n, ras_n, cas_n, we_n, cke, dq_oe;
    logic [12:0] addr;

    sdram_ctrl dut (
        .clk(clk), .reset(reset), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .sdram_cs_n(cs_n), .sdram_ras_n(ras_n), .sdram_cas_n(cas_n), .sdram_we_n(we_n),
        .sdram_cke(cke), .sdram_ba(ba), .sdram_addr(addr), .sdram_dqm(dqm),
        .sdram_dq_out(dq_out), .sdram_dq_oe(dq_oe), .sdram_dq_in(dq_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
        logic        oe;
        logic [1:0]  dqm;
        logic [15:0] dq;
    } ev_t;

    ev_t         ev_q[$];
    int          rsp_c[$];
    logic [15:0] rsp_d[$];
    logic [15:0] mem [int];
    logic [12:0] act_row [4];
    int          cyc = 0;
    int          n_acc = 0;
    int          rd_cyc = -100;
    int          rd_key = 0;
    int          n_chk = 0;
    int          n_pass = 0;

    localparam logic [23:0] KEY_A = {2'd1, 13'h123, 9'h045};
    localparam logic [23:0] KEY_B = {2'd2, 13'h055, 9'h01A};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset && req_valid && req_ready) n_acc <= n_acc + 1;
    end

    // SDRAM model and command/response logger, evaluated mid-cycle.
    always @(negedge clk) begin
        logic [3:0] cmd;
        int key;
        cmd = {cs_n, ras_n, cas_n, we_n};
        if (cmd != C_NOP && cmd != C_INH) begin
            ev_q.push_back('{cyc, cmd, ba, addr, dq_oe, dqm, dq_out});
            key = int'({ba, act_row[ba], addr[8:0]});
            if (cmd == C_ACT) act_row[ba] = addr;
            if (cmd == C_WR) begin
                if (!mem.exists(key)) mem[key] = 16'h0000;
                if (!dqm[0]) mem[key][7:0]  = dq_out[7:0];
                if (!dqm[1]) mem[key][15:8] = dq_out[15:8];
            end
            if (cmd == C_RD) begin
                rd_cyc = cyc;
                rd_key = key;
            end
        end
        if (cyc == rd_cyc + CL) dq_in = mem.exists(rd_key) ? mem[rd_key] : 16'h0000;
        else                    dq_in = 16'hDEAD;
        if (rsp_valid) begin
            rsp_c.push_back(cyc);
            rsp_d.push_back(rsp_rdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic clr_logs();
        ev_q.delete();
        rsp_c.delete();
        rsp_d.delete();
    endtask

    // Called just after a negedge; returns with the request dropped one cycle after acceptance.
    task automatic do_req(input bit wr, input logic [23:0] a, input logic [15:0] d,
                          input logic [1:0] m, output int c0);
        int n = 0;
        while (!req_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_timeout", 32'(n < 2000), 32'd1);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_wmask = m;
        c0 = cyc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    logic rdy_at [13];
    logic oe_at  [13];
    logic [1:0] dqm_at [13];

    task automatic observe();
        for (int i = 2; i <= 12; i++) begin
            @(negedge clk);
            rdy_at[i] = req_ready;
            oe_at[i]  = dq_oe;
            dqm_at[i] = dqm;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c0, acc0, acc_c;
        reset = 1'b1; init_done = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_addr = '0; req_wdata = '0; req_wmask = '0;
        mem[int'(KEY_A)] = 16'hBEEF;
        mem[int'(KEY_B)] = 16'h1234;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_cmd", {cs_n, ras_n, cas_n, we_n}, C_INH);
        chk("rst_cke", cke, 1'b0);
        chk("rst_oe_dqm_rdy_rsp", {dq_oe, dqm, req_ready, rsp_valid}, 5'b0_11_0_0);
        reset = 1'b0;

        // init_done rises at cycle 10
        while (cyc < 10) @(negedge clk);
        chk("init_c10_cmd_cke", {cs_n, ras_n, cas_n, we_n, cke}, {C_INH, 1'b0});
        init_done = 1'b1;
        @(negedge clk);
        chk("init_c11_cmd_cke", {cs_n, ras_n, cas_n, we_n, cke}, {C_NOP, 1'b1});
        chk("init_c11_ready", req_ready, 1'b1);

        // Read bank 1 row 0x123 col 0x45
        clr_logs();
        do_req(1'b0, KEY_A, 16'h0, 2'b00, c0);
        observe();
        chk("rd_ev_count", ev_q.size(), 2);
        chk("rd_act_time", ev_q[0].c - c0, 1);
        chk("rd_act_cmd_ba_addr", {ev_q[0].cmd, ev_q[0].ba, ev_q[0].addr}, {C_ACT, 2'd1, 13'h123});
        chk("rd_read_time", ev_q[1].c - c0, 3);
        chk("rd_read_cmd_ba_addr", {ev_q[1].cmd, ev_q[1].ba, ev_q[1].addr}, {C_RD, 2'd1, 13'h445});
        chk("rd_rsp_count", rsp_c.size(), 1);
        chk("rd_rsp_time", rsp_c[0] - c0, 6);
        chk("rd_rsp_data", rsp_d[0], 16'hBEEF);
        chk("rd_ready_c6_c7", {rdy_at[6], rdy_at[7]}, 2'b01);

        // Write 0xA5A5 low byte only to bank 2 row 0x055 col 0x1A
        clr_logs();
        do_req(1'b1, KEY_B, 16'hA5A5, 2'b01, c0);
        observe();
        chk("wr_ev_count", ev_q.size(), 2);
        chk("wr_act", {ev_q[0].c - c0, 28'(ev_q[0].cmd)}, {32'd1, 28'(C_ACT)});
        chk("wr_write_time", ev_q[1].c - c0, 3);
        chk("wr_write_cmd_addr", {ev_q[1].cmd, ev_q[1].ba, ev_q[1].addr}, {C_WR, 2'd2, 13'h41A});
        chk("wr_write_oe_dqm_dq", {ev_q[1].oe, ev_q[1].dqm, ev_q[1].dq}, {1'b1, 2'b10, 16'hA5A5});
        chk("wr_after_oe_dqm", {oe_at[4], dqm_at[4]}, 3'b0_11);
        chk("wr_ready_c7_c8", {rdy_at[7], rdy_at[8]}, 2'b01);
        chk("wr_no_rsp", rsp_c.size(), 0);
        chk("wr_mem", mem[int'(KEY_B)], 16'h12A5);

        // Idle refresh: first REFRESH at 792, then every 781 cycles
        clr_logs();
        while (cyc < 2364) @(negedge clk);
        chk("ref_count", ev_q.size(), 3);
        chk("ref_cmds", {ev_q[0].cmd, ev_q[1].cmd, ev_q[2].cmd}, {C_REF, C_REF, C_REF});
        chk("ref_first", ev_q[0].c, 792);
        chk("ref_gap1", ev_q[1].c - ev_q[0].c, 781);
        chk("ref_gap2", ev_q[2].c - ev_q[1].c, 781);

        // Collision: request raised in the cycle refresh_pending is high (REFRESH due at 3135)
        clr_logs();
        while (cyc < 3134) @(negedge clk);
        chk("col_ready_low", req_ready, 1'b0);
        acc0 = n_acc; acc_c = -1;
        req_valid = 1'b1; req_write = 1'b0; req_addr = KEY_A;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (acc_c >= 0) req_valid = 1'b0;
            else if (req_ready) acc_c = cyc;
        end
        req_valid = 1'b0;
        chk("col_ev_count", ev_q.size(), 3);
        chk("col_ref", {ev_q[0].c, 28'(ev_q[0].cmd)}, {32'd3135, 28'(C_REF)});
        chk("col_act", {ev_q[1].c, 28'(ev_q[1].cmd)}, {32'd3143, 28'(C_ACT)});
        chk("col_read_time", ev_q[2].c, 3145);
        chk("col_accept_cycle", acc_c, 3142);
        chk("col_accept_once", n_acc - acc0, 1);
        chk("col_rsp", {rsp_c.size(), 16'(rsp_d[0])}, {32'd1, 16'hBEEF});

        // Reset during RD_WAIT drops the response
        clr_logs();
        do_req(1'b0, KEY_A, 16'h0, 2'b00, c0);
        repeat (3) @(negedge clk);
        reset = 1'b1; init_done = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_cke", {cs_n, ras_n, cas_n, we_n, cke}, {C_INH, 1'b0});
        chk("mid_rst_rsp_rdy_oe", {rsp_valid, req_ready, dq_oe}, 3'b000);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("mid_rst_no_rsp", rsp_c.size(), 0);
        init_done = 1'b1;
        repeat (2) @(negedge clk);
        do_req(1'b0, KEY_A, 16'h0, 2'b00, c0);
        observe();
        chk("resume_rsp_count", rsp_c.size(), 1);
        chk("resume_rsp", {rsp_c[0] - c0, 16'(rsp_d[0])}, {32'd6, 16'hBEEF});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
